// File: rtl/elevator_dir_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : elevator_dir_matrix_scan
// Purpose  : Column-scan driver for the elevator direction dot-matrix panel.
//            Shows one 5-column arrow glyph per car: scrolling up/down arrows
//            for moving cars, a two-dot idle marker and a blinking fault block.
//            Single clock; the column step is a clock-enable from a prescaler.
// Ports    : clk      - system clock (only clock)
//            resetn   - asynchronous active-low reset
//            elv_dir  - car k at [2k+1:2k]: 00 idle, 01 up, 10 down, 11 fault
//            blank    - 1 = panel dark (counters keep running)
//            dot_col  - one-hot column select, active high, car k owns 5k..5k+4
//            dot_raw  - row drive, active low (0 = lit)
// Revision : 1.0 - initial release
// ============================================================================
module elevator_dir_matrix_scan #(
  parameter int NUM_ELV       = 2,
  parameter int ROWS          = 14,
  parameter int SCAN_DIV      = 6000,
  parameter int SCROLL_FRAMES = 8,
  parameter int BLINK_FRAMES  = 25,
  parameter int ANIMATE       = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [2*NUM_ELV-1:0] elv_dir,
  input  logic                 blank,
  output logic [5*NUM_ELV-1:0] dot_col,
  output logic [ROWS-1:0]      dot_raw
);

  localparam int c_ncol  = 5 * NUM_ELV;
  localparam int c_pre_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_col_w = $clog2(c_ncol);
  localparam int c_p_w   = $clog2(ROWS);
  localparam int c_sc_w  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int c_bl_w  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int c_mid   = ROWS / 2;

  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(SCAN_DIV - 1);
  localparam logic [c_col_w-1:0] c_col_last = c_col_w'(c_ncol - 1);
  localparam logic [c_col_w-1:0] c_col_five = c_col_w'(5);
  localparam logic [c_p_w-1:0]   c_p_last   = c_p_w'(ROWS - 1);
  localparam logic [c_sc_w-1:0]  c_sc_last  = c_sc_w'(SCROLL_FRAMES - 1);
  localparam logic [c_bl_w-1:0]  c_bl_last  = c_bl_w'(BLINK_FRAMES - 1);
  localparam logic [c_ncol-1:0]  c_col_one  = c_ncol'(1);

  localparam logic [1:0] c_dir_up    = 2'b01;
  localparam logic [1:0] c_dir_down  = 2'b10;
  localparam logic [1:0] c_dir_fault = 2'b11;

  // Single-row mask for row (base - p) mod ROWS; base is small and p < ROWS.
  function automatic logic [ROWS-1:0] row_mask(input int base, input logic [c_p_w-1:0] p);
    int              idx;
    logic [ROWS-1:0] one;
    one = ROWS'(1);
    idx = (base >= int'(p)) ? (base - int'(p)) : (base + ROWS - int'(p));
    return one << idx;
  endfunction

  // Lit-row mask (1 = lit) of one car column c for the given direction state.
  function automatic logic [ROWS-1:0] glyph(input logic [1:0]       dir,
                                            input logic [c_p_w-1:0] p,
                                            input logic [2:0]       c,
                                            input logic             bon);
    logic [ROWS-1:0] up;
    logic [ROWS-1:0] m;
    case (c)
      3'd0, 3'd4: up = row_mask(2, p) | row_mask(3, p);
      3'd1, 3'd3: up = row_mask(1, p) | row_mask(2, p);
      3'd2:       up = '1;
      default:    up = '0;
    endcase
    case (dir)
      c_dir_up:    m = up;
      c_dir_down:  m = {<<{up}};  // bit reverse mirrors row r to ROWS-1-r
      c_dir_fault: m = {ROWS{bon}};
      default:     m = (c == 3'd2) ? (row_mask(c_mid - 1, '0) | row_mask(c_mid, '0)) : '0;
    endcase
    return m;
  endfunction

  logic [c_pre_w-1:0] pre_q, pre_d;
  logic [c_col_w-1:0] col_q, col_d;
  logic [c_sc_w-1:0]  scroll_q, scroll_d;
  logic [c_bl_w-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               started_q, started_d;
  logic [c_ncol-1:0]  dot_col_q, dot_col_d;
  logic [ROWS-1:0]    dot_raw_q, dot_raw_d;

  logic               w_tick;
  logic               w_frame;
  logic               w_count;
  logic               w_scroll_wrap;
  logic               w_blink_wrap;
  logic [NUM_ELV:0][ROWS-1:0] w_lit_acc;

  always_comb begin
    w_tick  = (pre_q == c_pre_last);
    pre_d   = w_tick ? '0 : pre_q + 1'b1;
    col_d   = col_q;
    w_frame = 1'b0;
    if (w_tick) begin
      w_frame = (col_q == c_col_last);
      col_d   = w_frame ? '0 : col_q + 1'b1;
    end
    // The very first boundary after reset starts frame 0 without ending one,
    // so the frame counters only advance on boundaries after it.
    w_count       = w_frame & started_q;
    w_scroll_wrap = w_count & (scroll_q == c_sc_last);
    w_blink_wrap  = w_count & (blink_cnt_q == c_bl_last);
    scroll_d      = scroll_q;
    blink_cnt_d   = blink_cnt_q;
    if (w_count) begin
      scroll_d    = w_scroll_wrap ? '0 : scroll_q + 1'b1;
      blink_cnt_d = w_blink_wrap ? '0 : blink_cnt_q + 1'b1;
    end
    blink_on_d = blink_on_q ^ w_blink_wrap;
    started_d  = started_q | w_tick;
    dot_col_d  = blank ? '0 : (c_col_one << col_d);
    dot_raw_d  = blank ? '1 : ~w_lit_acc[NUM_ELV];
  end

  assign w_lit_acc[0] = '0;

  for (genvar k = 0; k < NUM_ELV; k++) begin : g_car
    localparam logic [c_col_w-1:0] c_lo = c_col_w'(5 * k);

    logic [1:0]         ldir_q, ldir_d;
    logic [c_p_w-1:0]   p_q, p_d;
    logic [c_col_w-1:0] w_off;
    logic               w_sel;
    logic [ROWS-1:0]    w_lit;

    always_comb begin
      ldir_d = ldir_q;
      p_d    = p_q;
      if (w_frame) begin
        ldir_d = elv_dir[2*k +: 2];
        if (ldir_d != ldir_q) begin
          p_d = '0;  // a direction change beats a coincident scroll step
        end else if ((ANIMATE != 0) && w_scroll_wrap &&
                     ((ldir_q == c_dir_up) || (ldir_q == c_dir_down))) begin
          p_d = (p_q == c_p_last) ? '0 : p_q + 1'b1;
        end
      end
    end

    // Wrapped offset: columns below this car's range land far above 4.
    assign w_off = col_d - c_lo;
    assign w_sel = (w_off < c_col_five);
    assign w_lit = glyph(ldir_d, p_d, w_off[2:0], blink_on_d);
    assign w_lit_acc[k+1] = w_lit_acc[k] | (w_sel ? w_lit : '0);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        ldir_q <= 2'b00;
        p_q    <= '0;
      end else begin
        ldir_q <= ldir_d;
        p_q    <= p_d;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q       <= '0;
      col_q       <= c_col_last;
      scroll_q    <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      started_q   <= 1'b0;
      dot_col_q   <= '0;
      dot_raw_q   <= '1;
    end else begin
      pre_q       <= pre_d;
      col_q       <= col_d;
      scroll_q    <= scroll_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      started_q   <= started_d;
      if (w_tick) begin
        dot_col_q <= dot_col_d;
        dot_raw_q <= dot_raw_d;
      end
    end
  end

  assign dot_col = dot_col_q;
  assign dot_raw = dot_raw_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_dir_matrix_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_dir_matrix_scan
// Purpose  : Self-checking bench. Two instances share the stimulus: one with
//            scrolling arrows, one static. A frame-level model predicts both
//            every cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_dir_matrix_scan;

  localparam int NUM_ELV = 2;
  localparam int ROWS    = 14;
  localparam int SD      = 4;
  localparam int SF      = 1;
  localparam int BF      = 2;
  localparam int NCOL    = 5 * NUM_ELV;

  logic                 clk     = 1'b0;
  logic                 resetn  = 1'b1;
  logic                 blank   = 1'b0;
  logic [2*NUM_ELV-1:0] elv_dir = '0;
  logic [NCOL-1:0]      col_a, col_s;
  logic [ROWS-1:0]      raw_a, raw_s;

  always #5 clk = ~clk;

  elevator_dir_matrix_scan #(
    .NUM_ELV(NUM_ELV), .ROWS(ROWS), .SCAN_DIV(SD),
    .SCROLL_FRAMES(SF), .BLINK_FRAMES(BF), .ANIMATE(1)
  ) u_dut_anim (
    .clk(clk), .resetn(resetn), .elv_dir(elv_dir), .blank(blank),
    .dot_col(col_a), .dot_raw(raw_a)
  );

  elevator_dir_matrix_scan #(
    .NUM_ELV(NUM_ELV), .ROWS(ROWS), .SCAN_DIV(SD),
    .SCROLL_FRAMES(SF), .BLINK_FRAMES(BF), .ANIMATE(0)
  ) u_dut_static (
    .clk(clk), .resetn(resetn), .elv_dir(elv_dir), .blank(blank),
    .dot_col(col_s), .dot_raw(raw_s)
  );

  int nchk  = 0;
  int nfail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Lit rows (1 = lit) of car column c, derived directly from the glyph rules.
  function automatic logic [ROWS-1:0] mlit(input logic [1:0] d, input int p,
                                           input int c, input bit bon);
    logic [ROWS-1:0] m;
    int r;
    m = '0;
    if (d == 2'b11) return bon ? {ROWS{1'b1}} : {ROWS{1'b0}};
    if (d == 2'b00) begin
      if (c == 2) begin
        m[ROWS/2-1] = 1'b1;
        m[ROWS/2]   = 1'b1;
      end
      return m;
    end
    if (c == 2) return {ROWS{1'b1}};
    for (int h = 0; h < 2; h++) begin
      r = ((c == 0 || c == 4) ? 2 : 1) + h - p;
      r = ((r % ROWS) + ROWS) % ROWS;
      if (d == 2'b10) r = ROWS - 1 - r;
      m[r] = 1'b1;
    end
    return m;
  endfunction

  // Model: time is counted in edges since reset; tick n shows column n mod NCOL
  // of frame n / NCOL. Scroll steps at frames f>0 with f mod SF == 0; blink is
  // lit while (f / BF) is even.
  int              mcyc;
  int              mcol;
  int              mf;
  int              mn;
  int              mcar;
  int              msub;
  bit              mbon;
  logic [1:0]      nd;
  logic [1:0]      mdir [NUM_ELV];
  int              mpa  [NUM_ELV];
  logic [NCOL-1:0] exp_col;
  logic [ROWS-1:0] exp_raw_a, exp_raw_s;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcyc = 0; mcol = NCOL - 1; mf = 0;
      exp_col = '0; exp_raw_a = '1; exp_raw_s = '1;
      for (int k = 0; k < NUM_ELV; k++) begin
        mdir[k] = 2'b00;
        mpa[k]  = 0;
      end
    end else begin
      mcyc++;
      if (mcyc % SD == 0) begin
        mn   = mcyc / SD - 1;
        mcol = mn % NCOL;
        mf   = mn / NCOL;
        if (mcol == 0) begin
          for (int k = 0; k < NUM_ELV; k++) begin
            nd = elv_dir[2*k +: 2];
            if (nd != mdir[k]) mpa[k] = 0;
            else if (mf > 0 && (mf % SF) == 0 && (nd == 2'b01 || nd == 2'b10))
              mpa[k] = (mpa[k] + 1) % ROWS;
            mdir[k] = nd;
          end
        end
        mcar = mcol / 5;
        msub = mcol % 5;
        mbon = ((mf / BF) % 2) == 0;
        if (blank) begin
          exp_col = '0; exp_raw_a = '1; exp_raw_s = '1;
        end else begin
          exp_col   = NCOL'(1) << mcol;
          exp_raw_a = ~mlit(mdir[mcar], mpa[mcar], msub, mbon);
          exp_raw_s = ~mlit(mdir[mcar], 0, msub, mbon);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_col_anim",   32'(col_a), 32'(exp_col));
      chk("cmp_raw_anim",   32'(raw_a), 32'(exp_raw_a));
      chk("cmp_col_static", 32'(col_s), 32'(exp_col));
      chk("cmp_raw_static", 32'(raw_s), 32'(exp_raw_s));
    end
  end

  // Waits for the negedge just after the tick that shows column c.
  task automatic wait_col(input int c);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      if (resetn && mcyc > 0 && (mcyc % SD) == 0 && mcol == c) hit = 1'b1;
    end
    if (!hit) begin
      nchk++; nfail++;
      $display("FAIL wait_col: column %0d not reached within 400 cycles", c);
    end
  endtask

  logic [ROWS-1:0] tbl_up    [5];
  logic [ROWS-1:0] tbl_blink [5];

  initial begin
    tbl_up[0] = 14'b11111111110011; tbl_up[1] = 14'b11111111111001;
    tbl_up[2] = 14'h0000;           tbl_up[3] = 14'b11111111111001;
    tbl_up[4] = 14'b11111111110011;
    tbl_blink[0] = 14'h0000; tbl_blink[1] = 14'h0000; tbl_blink[2] = 14'h3FFF;
    tbl_blink[3] = 14'h3FFF; tbl_blink[4] = 14'h0000;

    // Reset and idle
    #2 resetn = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_col", 32'(col_a), 32'h0);
    chk("rst_raw", 32'(raw_a), 32'h3FFF);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_first_tick_col", 32'(col_a), 32'h0);
    @(negedge clk);
    chk("first_tick_col", 32'(col_a), 32'h001);
    chk("first_tick_raw", 32'(raw_a), 32'h3FFF);
    wait_col(2);
    chk("idle_col2_raw", 32'(raw_s), 32'(14'b11111100111111));

    // Static arrows, both cars up
    elv_dir = 4'b0101;
    wait_col(0);
    for (int c = 0; c < NCOL; c++) begin
      if (c > 0) wait_col(c);
      chk($sformatf("static_up_col%0d", c), 32'(raw_s), 32'(tbl_up[c % 5]));
    end

    // Scrolling on the animated instance
    wait_col(0);
    chk("scroll_p1_col0", 32'(raw_a), 32'(14'b11111111111001));
    wait_col(0);
    wait_col(0);
    chk("scroll_p3_col0", 32'(raw_a), 32'(14'b01111111111110));
    chk("static_p0_col0", 32'(raw_s), 32'(14'b11111111110011));

    // Mixed: car0 up, car1 down
    elv_dir = 4'b1001;
    wait_col(0);
    wait_col(5);
    chk("mixed_col5_static", 32'(raw_s), 32'(14'b11001111111111));
    chk("mixed_col5_anim",   32'(raw_a), 32'(14'b11001111111111));
    wait_col(6);
    chk("mixed_col6_static", 32'(raw_s), 32'(14'b10011111111111));

    // car0 turns down: scroll phase restarts
    elv_dir = 4'b1010;
    wait_col(0);
    chk("dirchg_p0_col0_anim", 32'(raw_a), 32'(14'b11001111111111));

    // Mid-frame change has no effect until the next boundary
    wait_col(3);
    elv_dir = 4'b0011;
    wait_col(4);
    chk("midframe_col4", 32'(raw_s), 32'(14'b11001111111111));
    wait_col(5);
    chk("midframe_col5", 32'(raw_s), 32'(14'b11001111111111));

    // Reset pulse mid-frame
    wait_col(6);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_col", 32'(col_a), 32'h0);
    chk("midrst_raw", 32'(raw_a), 32'h3FFF);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Fault blink on car0, car1 idle
    wait_col(0);
    chk("blink_f0_col0", 32'(raw_a), 32'(tbl_blink[0]));
    wait_col(5);
    chk("idle_car1_col5", 32'(raw_a), 32'h3FFF);
    wait_col(7);
    chk("idle_car1_col7", 32'(raw_a), 32'(14'b11111100111111));
    for (int f = 1; f < 5; f++) begin
      wait_col(0);
      chk($sformatf("blink_f%0d_col0", f), 32'(raw_a), 32'(tbl_blink[f]));
    end

    // Blank takes effect at the next tick only
    wait_col(3);
    blank = 1'b1;
    @(negedge clk);
    chk("blank_before_tick", 32'(col_a), 32'h008);
    wait_col(4);
    chk("blank_col", 32'(col_a), 32'h0);
    chk("blank_raw", 32'(raw_a), 32'h3FFF);
    wait_col(0);
    blank = 1'b0;
    wait_col(0);
    chk("blink_f6_after_blank", 32'(raw_a), 32'h3FFF);
    wait_col(0);
    wait_col(0);
    chk("blink_f8_after_blank", 32'(raw_a), 32'h0000);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
